// File: rtl/fp32_to_bf16_rne_44.sv
`default_nettype none
// ============================================================================
// Module      : fp32_to_bf16_rne_44
// Description : Two-stage FP32 -> BF16 narrowing converter, round-to-nearest-
//               even, IEEE flags per result, saturating inexact counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_to_bf16_rne_44 #(
    parameter int FTZ   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk_44,
    input  logic             rst_n_44,
    input  logic             in_valid_44,
    output logic             in_ready_44,
    input  logic [31:0]      in_data_44,
    output logic             out_valid_44,
    input  logic             out_ready_44,
    output logic [15:0]      out_data_44,
    output logic [3:0]       out_flags_44,
    input  logic             clr_cnt_44,
    output logic [CNT_W-1:0] inex_cnt_44
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [7:0]       c_exp_max = 8'hFF;

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic        w_exp_max;
    logic        w_exp_zero;
    logic        w_man_zero;
    logic        w_lsb;
    logic        w_grd;
    logic        w_stk;
    logic        w_up;
    logic        w_nx;
    logic        w_flush;

    assign w_sign     = in_data_44[31];
    assign w_exp      = in_data_44[30:23];
    assign w_man      = in_data_44[22:0];
    assign w_exp_max  = (w_exp == c_exp_max);
    assign w_exp_zero = (w_exp == 8'h00);
    assign w_man_zero = (w_man == 23'h0);
    assign w_lsb      = w_man[16];
    assign w_grd      = w_man[15];
    assign w_stk      = |w_man[14:0];
    assign w_up       = w_grd & (w_stk | w_lsb);
    assign w_nx       = w_grd | w_stk;

    generate
        if (FTZ != 0) begin : g_ftz
            assign w_flush = w_exp_zero & ~w_man_zero;
        end else begin : g_no_ftz
            assign w_flush = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // S1 next-state: finite operands keep {e, m[22:16]} plus a round-up bit;
    // specials carry their final payload and bypass the rounding checks.
    // ------------------------------------------------------------------
    logic [14:0] w_s1_body;
    logic        w_s1_up;
    logic        w_s1_fin;
    logic [3:0]  w_s1_flags;

    always_comb begin
        w_s1_body  = {w_exp, w_man[22:16]};
        w_s1_up    = w_up;
        w_s1_fin   = 1'b1;
        w_s1_flags = {3'b000, w_nx};
        if (w_exp_max) begin
            w_s1_fin = 1'b0;
            w_s1_up  = 1'b0;
            if (w_man_zero) begin
                w_s1_body  = {c_exp_max, 7'h00};
                w_s1_flags = 4'h0;
            end else begin
                // NaNs are always returned quiet; nv marks a signaling input
                w_s1_body  = {c_exp_max, 1'b1, w_man[21:16]};
                w_s1_flags = {~w_man[22], 3'b000};
            end
        end else if (w_flush) begin
            w_s1_fin   = 1'b0;
            w_s1_up    = 1'b0;
            w_s1_body  = 15'h0;
            w_s1_flags = 4'b0011;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [14:0] r_s1_body;
    logic        r_s1_up;
    logic        r_s1_fin;
    logic [3:0]  r_s1_flags;
    logic        r_s2_valid;
    logic [15:0] r_s2_data;
    logic [3:0]  r_s2_flags;
    logic        w_adv;
    logic        w_s1_load;
    logic        w_out_xfer;

    assign w_adv       = ~r_s2_valid | out_ready_44;
    assign in_ready_44 = ~r_s1_valid | w_adv;
    // An empty S1 may always fill, even while S2 is stalled
    assign w_s1_load   = w_adv | ~r_s1_valid;
    assign w_out_xfer  = r_s2_valid & out_ready_44;

    always_ff @(posedge clk_44 or negedge rst_n_44) begin
        if (!rst_n_44) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_body  <= 15'h0;
            r_s1_up    <= 1'b0;
            r_s1_fin   <= 1'b0;
            r_s1_flags <= 4'h0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid_44;
            if (in_valid_44) begin
                r_s1_sign  <= w_sign;
                r_s1_body  <= w_s1_body;
                r_s1_up    <= w_s1_up;
                r_s1_fin   <= w_s1_fin;
                r_s1_flags <= w_s1_flags;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 next-state: 15-bit increment on {e, f}; a mantissa carry ripples
    // into the exponent. The largest finite exponent is FE, so the sum
    // never exceeds {FF, 00}.
    // ------------------------------------------------------------------
    logic [14:0] w_sum;
    logic        w_ovf;
    logic [15:0] w_s2_data;
    logic [3:0]  w_s2_flags;

    assign w_sum = r_s1_body + {14'h0, r_s1_up};
    assign w_ovf = r_s1_fin & (w_sum[14:7] == c_exp_max);

    always_comb begin
        w_s2_data  = {r_s1_sign, w_sum};
        w_s2_flags = r_s1_flags;
        if (w_ovf) begin
            w_s2_data  = {r_s1_sign, c_exp_max, 7'h00};
            w_s2_flags = 4'b0101;
        end else if (r_s1_fin) begin
            w_s2_flags[1] = r_s1_flags[0] & (w_sum[14:7] == 8'h00);
        end
    end

    always_ff @(posedge clk_44 or negedge rst_n_44) begin
        if (!rst_n_44) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= 16'h0;
            r_s2_flags <= 4'h0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data  <= w_s2_data;
                r_s2_flags <= w_s2_flags;
            end
        end
    end

    assign out_valid_44 = r_s2_valid;
    assign out_data_44  = r_s2_data;
    assign out_flags_44 = r_s2_flags;

    // ------------------------------------------------------------------
    // Inexact counter: clear has priority over a same-cycle increment
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_44 or negedge rst_n_44) begin
        if (!rst_n_44) begin
            r_cnt <= '0;
        end else if (clr_cnt_44) begin
            r_cnt <= '0;
        end else if (w_out_xfer && r_s2_flags[0] && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign inex_cnt_44 = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_bf16_rne_44.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fp32_to_bf16_rne_44
// Description : Randomized and directed bench with a scoreboard model for the
//               FP32 -> BF16 converter (FTZ=0 and FTZ=1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_to_bf16_rne_44;

    logic        clk_44 = 1'b0;
    logic        rst_n_44;
    logic        in_valid_44;
    logic [31:0] in_data_44;
    logic        out_ready_44;
    logic        clr_cnt_44;
    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [15:0] out_data0, out_data1;
    logic [3:0]  flags0, flags1, cnt0, cnt1;

    always #5 clk_44 = ~clk_44;

    fp32_to_bf16_rne_44 #(.FTZ(0), .CNT_W(4)) u_dut0 (
        .clk_44(clk_44), .rst_n_44(rst_n_44),
        .in_valid_44(in_valid_44), .in_ready_44(in_ready0), .in_data_44(in_data_44),
        .out_valid_44(out_valid0), .out_ready_44(out_ready_44),
        .out_data_44(out_data0), .out_flags_44(flags0),
        .clr_cnt_44(clr_cnt_44), .inex_cnt_44(cnt0));

    fp32_to_bf16_rne_44 #(.FTZ(1), .CNT_W(4)) u_dut1 (
        .clk_44(clk_44), .rst_n_44(rst_n_44),
        .in_valid_44(in_valid_44), .in_ready_44(in_ready1), .in_data_44(in_data_44),
        .out_valid_44(out_valid1), .out_ready_44(out_ready_44),
        .out_data_44(out_data1), .out_flags_44(flags1),
        .clr_cnt_44(clr_cnt_44), .inex_cnt_44(cnt1));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by the test
    int n_acc = 0;

    typedef struct {
        logic [19:0] e0;
        logic [19:0] e1;
        int          stamp;
    } exp_t;
    exp_t q[$];
    int   m_cnt0 = 0;
    int   m_cnt1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference conversion: returns {nv, of, uf, nx, bf16}
    function automatic logic [19:0] ref_conv(input logic [31:0] x, input bit ftz);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [31:0] mag, r;
        logic        nx, uf;
        s = x[31];
        e = x[30:23];
        m = x[22:0];
        if (e == 8'hFF) begin
            if (m == 23'h0) return {4'h0, s, 15'h7F80};
            return {~m[22], 3'b000, s, 8'hFF, 1'b1, m[21:16]};
        end
        if (e == 8'h00 && ftz) return {2'b00, m != 23'h0, m != 23'h0, s, 15'h0};
        mag = {1'b0, x[30:0]};
        // Adding just under half an ulp, plus the lsb, rounds half to even
        r   = (mag + 32'h7FFF + ((mag >> 16) & 32'h1)) >> 16;
        nx  = (mag & 32'hFFFF) != 32'h0;
        if (r >= 32'h7F80) return {4'b0101, s, 15'h7F80};
        uf  = nx && (r < 32'h80);
        return {2'b00, uf, nx, s, r[14:0]};
    endfunction

    always @(posedge clk_44) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk_44);
            #1;
            if (rdy_mode == 0) out_ready_44 = 1'b1;
            else if (rdy_mode == 1) out_ready_44 = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard: checks every visible output each cycle against the model
    always @(negedge clk_44) begin
        if (!rst_n_44) begin
            q.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
            chk("rst_out_valid0", out_valid0, 1'b0);
            chk("rst_out_valid1", out_valid1, 1'b0);
            chk("rst_out_data0", out_data0, 16'h0);
            chk("rst_flags1", flags1, 4'h0);
            chk("rst_cnt0", cnt0, 4'h0);
        end else begin
            bit exp_ov;
            bit exp_rdy;
            exp_rdy = (q.size() < 2) || out_ready_44;
            exp_ov  = (q.size() > 0) && (cyc >= q[0].stamp + 2);
            chk("in_ready0", in_ready0, exp_rdy);
            chk("in_ready1", in_ready1, exp_rdy);
            chk("out_valid0", out_valid0, exp_ov);
            chk("out_valid1", out_valid1, exp_ov);
            chk("inex_cnt0", cnt0, m_cnt0[3:0]);
            chk("inex_cnt1", cnt1, m_cnt1[3:0]);
            if (exp_ov) begin
                chk("out_data0", out_data0, q[0].e0[15:0]);
                chk("out_flags0", flags0, q[0].e0[19:16]);
                chk("out_data1", out_data1, q[0].e1[15:0]);
                chk("out_flags1", flags1, q[0].e1[19:16]);
            end
            if (clr_cnt_44) begin
                m_cnt0 = 0;
                m_cnt1 = 0;
            end else if (exp_ov && out_ready_44) begin
                if (q[0].e0[16] && m_cnt0 < 15) m_cnt0++;
                if (q[0].e1[16] && m_cnt1 < 15) m_cnt1++;
            end
            if (exp_ov && out_ready_44) void'(q.pop_front());
            if (in_valid_44 && exp_rdy) begin
                exp_t t;
                t.e0    = ref_conv(in_data_44, 1'b0);
                t.e1    = ref_conv(in_data_44, 1'b1);
                t.stamp = cyc;
                q.push_back(t);
                n_acc++;
            end
        end
    end

    task automatic send(input logic [31:0] x);
        bit done;
        done = 1'b0;
        in_valid_44 = 1'b1;
        in_data_44  = x;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_44);
            done = in_ready0;
            @(posedge clk_44);
            #1;
        end
        in_valid_44 = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: operand %h never accepted", x);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk_44);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results still pending, expected 0", q.size());
        end
        @(posedge clk_44);
        #1;
    endtask

    task automatic step();
        @(posedge clk_44);
        #1;
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0: x[30:23] = 8'h00;
            1: x[30:23] = 8'hFF;
            2: x[30:23] = 8'hFE;
            3: x[15:0]  = 16'h8000;
            4: begin x[30:23] = 8'h00; x[22:16] = 7'h0; end
            default: ;
        endcase
        return x;
    endfunction

    logic [31:0] pin_x [11];
    logic [19:0] pin_e0[11];
    logic [19:0] pin_e1[11];

    initial begin
        logic [15:0] held;
        int          acc0;
        bit          seen;

        pin_x[0]  = 32'h3F800000; pin_e0[0]  = 20'h0_3F80; pin_e1[0]  = 20'h0_3F80;
        pin_x[1]  = 32'h3F808000; pin_e0[1]  = 20'h1_3F80; pin_e1[1]  = 20'h1_3F80;
        pin_x[2]  = 32'h3F818000; pin_e0[2]  = 20'h1_3F82; pin_e1[2]  = 20'h1_3F82;
        pin_x[3]  = 32'h3F808001; pin_e0[3]  = 20'h1_3F81; pin_e1[3]  = 20'h1_3F81;
        pin_x[4]  = 32'hBF7FFFFF; pin_e0[4]  = 20'h1_BF80; pin_e1[4]  = 20'h1_BF80;
        pin_x[5]  = 32'h7F7FFFFF; pin_e0[5]  = 20'h5_7F80; pin_e1[5]  = 20'h5_7F80;
        pin_x[6]  = 32'hFF800000; pin_e0[6]  = 20'h0_FF80; pin_e1[6]  = 20'h0_FF80;
        pin_x[7]  = 32'h7F800001; pin_e0[7]  = 20'h8_7FC0; pin_e1[7]  = 20'h8_7FC0;
        pin_x[8]  = 32'hFFC00000; pin_e0[8]  = 20'h0_FFC0; pin_e1[8]  = 20'h0_FFC0;
        pin_x[9]  = 32'h00400000; pin_e0[9]  = 20'h0_0040; pin_e1[9]  = 20'h3_0000;
        pin_x[10] = 32'h00008000; pin_e0[10] = 20'h3_0000; pin_e1[10] = 20'h3_0000;

        rst_n_44     = 1'b0;
        in_valid_44  = 1'b0;
        in_data_44   = 32'h0;
        out_ready_44 = 1'b1;
        clr_cnt_44   = 1'b0;
        repeat (3) step();
        rst_n_44 = 1'b1;
        @(negedge clk_44);
        chk("ready_after_reset", in_ready0, 1'b1);
        step();

        // The model must agree with hand-derived results
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("model_ftz0_%08h", pin_x[i]), ref_conv(pin_x[i], 1'b0), pin_e0[i]);
            chk($sformatf("model_ftz1_%08h", pin_x[i]), ref_conv(pin_x[i], 1'b1), pin_e1[i]);
        end

        // Latency: accepted at N, valid at N+2
        send(32'h3F800000);
        step();
        @(negedge clk_44);
        chk("lat_valid", out_valid0, 1'b1);
        chk("lat_data", {flags0, out_data0}, 20'h0_3F80);
        drain();

        for (int i = 0; i < 11; i++) send(pin_x[i]);
        drain();

        // Backpressure: stall begins just after the first result leaves
        rdy_mode = 2;
        out_ready_44 = 1'b1;
        acc0 = n_acc;
        in_valid_44 = 1'b1;
        in_data_44 = 32'h40000000; step();
        in_data_44 = 32'h40400000; step();
        in_data_44 = 32'h40800000; step();
        out_ready_44 = 1'b0;
        in_data_44 = 32'h40A00000;
        @(negedge clk_44);
        held = out_data0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_44);
            chk("stall_hold", out_data0, held);
            chk("stall_ready", in_ready0, 1'b0);
            step();
        end
        chk("stall_accepted", n_acc - acc0, 3);
        out_ready_44 = 1'b1;
        send(32'h40A00000);
        rdy_mode = 0;
        drain();

        // Randomized traffic with random backpressure and gaps
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(rnd_fp());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        end
        rdy_mode = 0;
        drain();

        // Counter saturation at CNT_W = 4
        clr_cnt_44 = 1'b1; step(); clr_cnt_44 = 1'b0;
        for (int i = 0; i < 20; i++) send(32'h3F808001);
        drain();
        @(negedge clk_44);
        chk("cnt_sat0", cnt0, 4'hF);
        chk("cnt_sat1", cnt1, 4'hF);
        step();

        // Clear coincident with an inexact transfer
        rdy_mode = 2;
        out_ready_44 = 1'b0;
        send(32'h3F808001);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = out_valid0;
        end
        chk("clr_setup_valid", out_valid0, 1'b1);
        clr_cnt_44 = 1'b1;
        out_ready_44 = 1'b1;
        step();
        clr_cnt_44 = 1'b0;
        @(negedge clk_44);
        chk("clr_wins0", cnt0, 4'h0);
        chk("clr_wins1", cnt1, 4'h0);
        step();

        // Reset mid-stream with a full pipeline
        out_ready_44 = 1'b0;
        send(32'h3F808001);
        send(32'h40490FDB);
        #2;
        rst_n_44 = 1'b0;
        #1;
        chk("midrst_valid0", out_valid0, 1'b0);
        chk("midrst_valid1", out_valid1, 1'b0);
        step();
        rst_n_44 = 1'b1;
        rdy_mode = 0;
        repeat (5) begin
            @(negedge clk_44);
            chk("no_stale", out_valid0, 1'b0);
            step();
        end
        send(32'h3F818000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
